hs_src_arb: RTL and testbench
=============================

Name: hs_src_arb

Overview:
- Source-side controller for request/acknowledge transfers, generalised to NCH independent producer channels.
- Each channel gets a one-deep holding register. Channels are granted round-robin onto a single shared req/ack link.
- The link runs either 4-phase (return-to-zero) or 2-phase (toggle) signalling, with an optional stuck-handshake timeout flag.
- The block sits in the source clock domain. ack arrives already passed through an NDFF_syn instance; xdata/xch are held stable for the destination to sample.

Parameters:
- WIDTH, 32: data width per channel.
- NCH, 4: number of producer channels, 1..16.
- PHASE4, 1: 1 = 4-phase req/ack, 0 = 2-phase toggle.
- TMO, 0: wait cycles before the timeout pulse; 0 disables the timeout.
- CW, max(1,clog2(NCH)): derived channel-index width. Not user-set.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  synchronous reset, active-low.
- sready  in  NCH  per-channel "din slice valid".
- din  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- sidle  out  NCH  channel i holding register empty; sready accepted.
- req  out  1  request to far domain, registered.
- ack  in  1  acknowledge, already synchronised to clk.
- xdata  out  WIDTH  data of the transfer in flight, registered.
- xch  out  CW  channel index of the transfer in flight, registered.
- timeout  out  1  one-cycle pulse when a handshake exceeds TMO cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending all 0, so sidle all 1.
  - req=0, xdata=0, xch=0, timeout=0, state=IDLE.
  - Round-robin pointer set so channel 0 has highest priority.
  - Reset mid-transfer drops all held data. The far side must be reset together; no recovery handshake.
- Capture:
  - sidle[i] is combinational: equals !pending[i].
  - At a clk edge with sready[i]=1 and sidle[i]=1: hold[i] <= din slice i, pending[i] <= 1.
  - sready[i] while sidle[i]=0 is ignored; the data is not latched.
- States: IDLE, WAIT_ACK1, WAIT_ACK0 (4-phase only), WAIT_TOG (2-phase only).
- IDLE with any pending bit set:
  - Grant g = first pending channel after the last granted one, cyclic.
  - At the same edge: xdata <= hold[g], xch <= g, pointer <= g.
  - 4-phase: req <= 1, go to WAIT_ACK1. 2-phase: req <= ~req, go to WAIT_TOG.
- Latency: capture at edge k gives req change at edge k+1 at the earliest, if the FSM is IDLE.
- 4-phase sequence:
  - WAIT_ACK1: on ack=1, req <= 0, pending[g] <= 0, go to WAIT_ACK0.
  - WAIT_ACK0: on ack=0, go to IDLE.
  - ack=1 while in IDLE is ignored.
- 2-phase sequence: WAIT_TOG, on ack==req, pending[g] <= 0, go to IDLE.
- Stability: xdata/xch change only on the grant edge; they hold through the whole handshake and after it.
- Spacing: at least one IDLE cycle between grants.
- Freed-channel timing: sidle[g] rises the cycle after the free edge. A sready[g] during the free cycle itself is ignored.
- Independence: captures on non-granted channels proceed freely during a transfer.
- Timeout (TMO>0):
  - Cycle counter runs in the WAIT_* states and clears on every state change.
  - When the count reaches TMO, timeout pulses once and the counter saturates.
  - The FSM keeps waiting; it never aborts a handshake.

Decomposition:
- Package hs_pkg:
  - State enum: IDLE=0, WAIT_ACK1=1, WAIT_ACK0=2, WAIT_TOG=3.
  - clog2 function.
  - Default-parameter constants.
- Sub-module rr_arbiter #(NCH):
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational.
- Top level owns holding registers, FSM, req/xdata/xch registers and the timeout counter.

Test Plan:
- PHASE4=1, NCH=4: sready[2] with din slice 0xDEADBEEF at edge 0 → sidle[2]=0 after edge 0; req=1, xch=2, xdata=0xDEADBEEF after edge 1. Drive ack=1 at edge 5 → req=0 and sidle[2]=1 after edge 5. Drive ack=0 → IDLE.
- Channels 0,1,3 pending simultaneously, responder acks each after 3 cycles → grant order 0,1,3. Re-fill all three → order continues 0,1,3 cyclically, not 0 every time.
- PHASE4=0: two transfers on channel 1 (0x11, then 0x22) → req toggles 0→1→0. Each completes when ack equals req. xdata 0x11 then 0x22.
- TMO=8: hold ack=0 after req=1 → timeout high for exactly one cycle, 8 cycles after req rose. req stays 1; late ack still completes normally.
- Assert rst_n=0 for one edge while in WAIT_ACK1 with channels 0 and 3 pending → req=0, xdata=0, sidle=4'b1111. Next grant after release is channel 0.
- sready[0]=1 during channel 0's free cycle → ignored, sidle[0] still 0 that cycle. sready held one more cycle → captured.

Source files
------------

// File: rtl/hs_src_arb_pkg.sv
// Shared types and helpers for the request/acknowledge source arbiter.
// Handshake FSM states, width helpers and default parameter values.
package hs_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK1 = 2'd1,
      WAIT_ACK0 = 2'd2,
      WAIT_TOG  = 2'd3
   } state_e;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NCH    = 4;
   localparam int DEF_PHASE4 = 1;
   localparam int DEF_TMO    = 0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int chw(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/hs_src_arb_if.sv
// Producer-side slices plus the shared req/ack link of hs_src_arb.
// master = the arbiter, slave = producers and far-side responder.
interface hs_src_arb_if import hs_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH,
   parameter int CW    = chw(NCH)
);
   logic [NCH-1:0]       sready;
   logic [NCH*WIDTH-1:0] din;
   logic [NCH-1:0]       sidle;
   logic                 req;
   logic                 ack;
   logic [WIDTH-1:0]     xdata;
   logic [CW-1:0]        xch;
   logic                 timeout;

   modport master (
      input  sready, din, ack,
      output sidle, req, xdata, xch, timeout
   );

   modport slave (
      output sready, din, ack,
      input  sidle, req, xdata, xch, timeout
   );
endinterface

// File: rtl/hs_src_arb_rr_arbiter.sv
// Combinational round-robin picker: nearest requester after last_i, cyclic.
module rr_arbiter import hs_pkg::*; #(
   parameter int NCH = DEF_NCH,
   parameter int CW  = chw(NCH)
) (
   input  logic [NCH-1:0] req_i,
   input  logic [CW-1:0]  last_i,
   output logic [NCH-1:0] gnt_o,
   output logic [CW-1:0]  idx_o,
   output logic           any_o
);
   int c;

   // Scan from farthest to nearest so the nearest requester overwrites last.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      c     = 0;
      for (int k = NCH; k >= 1; k--) begin
         c = (int'(last_i) + k) % NCH;
         if (req_i[c]) begin
            gnt_o    = '0;
            gnt_o[c] = 1'b1;
            idx_o    = CW'(c);
         end
      end
   end

   assign any_o = |req_i;
endmodule

// File: rtl/hs_src_arb.sv
// Multi-channel handshake source: per-channel one-deep holding registers,
// round-robin grant onto one req/ack link (4-phase or 2-phase), stuck timeout.
module hs_src_arb import hs_pkg::*; #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NCH    = DEF_NCH,
   parameter int PHASE4 = DEF_PHASE4,
   parameter int TMO    = DEF_TMO
) (
   input  logic          clk,
   input  logic          rst_n,
   hs_src_arb_if.master  bus
);
   localparam int CW = chw(NCH);
   localparam int TW = chw(TMO + 1);
   localparam logic [TW-1:0] TMO_C = TW'(TMO);

   logic [NCH-1:0][WIDTH-1:0] hold_q, hold_d;
   logic [NCH-1:0]            pend_q, pend_d, gnt;
   state_e                    st_q, st_d;
   logic                      req_q, req_d, tmo_q, tmo_d, any;
   logic [WIDTH-1:0]          xdata_q, xdata_d, gdata;
   logic [CW-1:0]             xch_q, xch_d, last_q, last_d, gidx;
   logic [TW-1:0]             cnt_q, cnt_d;

   rr_arbiter #(.NCH(NCH), .CW(CW)) u_rr (
      .req_i  (pend_q),
      .last_i (last_q),
      .gnt_o  (gnt),
      .idx_o  (gidx),
      .any_o  (any)
   );

   always_comb begin
      st_d    = st_q;
      req_d   = req_q;
      xdata_d = xdata_q;
      xch_d   = xch_q;
      last_d  = last_q;
      pend_d  = pend_q;
      hold_d  = hold_q;
      cnt_d   = '0;
      tmo_d   = 1'b0;
      gdata   = '0;

      for (int i = 0; i < NCH; i++) begin
         gdata = gdata | (gnt[i] ? hold_q[i] : '0);
         if (bus.sready[i] && !pend_q[i]) begin
            pend_d[i] = 1'b1;
            hold_d[i] = bus.din[i*WIDTH +: WIDTH];
         end
      end

      case (st_q)
         IDLE: if (any) begin
            xdata_d = gdata;
            xch_d   = gidx;
            last_d  = gidx;
            if (PHASE4 != 0) begin
               req_d = 1'b1;
               st_d  = WAIT_ACK1;
            end else begin
               req_d = ~req_q;
               st_d  = WAIT_TOG;
            end
         end
         WAIT_ACK1: if (bus.ack) begin
            req_d         = 1'b0;
            pend_d[xch_q] = 1'b0;
            st_d          = WAIT_ACK0;
         end
         WAIT_ACK0: if (!bus.ack) st_d = IDLE;
         WAIT_TOG: if (bus.ack == req_q) begin
            pend_d[xch_q] = 1'b0;
            st_d          = IDLE;
         end
         default: st_d = IDLE;
      endcase

      // Count only while stuck in one WAIT_* state; saturate at TMO.
      if (TMO > 0 && st_q != IDLE && st_d == st_q) begin
         if (cnt_q != TMO_C) begin
            cnt_d = cnt_q + 1'b1;
            tmo_d = ((cnt_q + 1'b1) == TMO_C);
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         req_q   <= 1'b0;
         xdata_q <= '0;
         xch_q   <= '0;
         last_q  <= CW'(NCH - 1);
         pend_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         req_q   <= req_d;
         xdata_q <= xdata_d;
         xch_q   <= xch_d;
         last_q  <= last_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // Held data is only meaningful while its pending bit is set.
   always_ff @(posedge clk) hold_q <= hold_d;

   assign bus.sidle   = ~pend_q;
   assign bus.req     = req_q;
   assign bus.xdata   = xdata_q;
   assign bus.xch     = xch_q;
   assign bus.timeout = tmo_q;
endmodule

// File: tb/tb_hs_src_arb.sv
// Bench for hs_src_arb: a 4-phase/TMO=8 instance and a 2-phase instance,
// directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_hs_src_arb;
   localparam int W = 32;
   localparam int N = 4;

   logic clk, rst_n;
   logic [N-1:0]   sr [2];
   logic [N*W-1:0] dn [2];
   logic           ak [2];

   logic [N-1:0] o_sidle [2];
   logic         o_req   [2];
   logic [W-1:0] o_xd    [2];
   logic [1:0]   o_xch   [2];
   logic         o_tmo   [2];

   int nchk = 0, npass = 0;

   hs_src_arb_if #(.WIDTH(W), .NCH(N)) i4 ();
   hs_src_arb_if #(.WIDTH(W), .NCH(N)) i2 ();

   hs_src_arb #(.WIDTH(W), .NCH(N), .PHASE4(1), .TMO(8)) u4 (
      .clk(clk), .rst_n(rst_n), .bus(i4.master));
   hs_src_arb #(.WIDTH(W), .NCH(N), .PHASE4(0), .TMO(0)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(i2.master));

   assign i4.sready = sr[0];
   assign i4.din    = dn[0];
   assign i4.ack    = ak[0];
   assign i2.sready = sr[1];
   assign i2.din    = dn[1];
   assign i2.ack    = ak[1];
   assign o_sidle[0] = i4.sidle;  assign o_sidle[1] = i2.sidle;
   assign o_req[0]   = i4.req;    assign o_req[1]   = i2.req;
   assign o_xd[0]    = i4.xdata;  assign o_xd[1]    = i2.xdata;
   assign o_xch[0]   = i4.xch;    assign o_xch[1]   = i2.xch;
   assign o_tmo[0]   = i4.timeout; assign o_tmo[1]  = i2.timeout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction model: phase 0 idle, 1 await ack high, 2 await ack low,
   // 3 await ack==req. Index 0 is the 4-phase unit, 1 the 2-phase unit.
   bit [N-1:0]  m_pend [2];
   logic [W-1:0] m_hold [2][N];
   bit          m_req [2];
   logic [W-1:0] m_xd [2];
   int          m_xch [2], m_last [2], m_ph [2], m_entry [2];
   bit          m_tmo [2];
   int          m_edge = 0;

   task automatic step();
      int e;
      e = m_edge + 1;
      for (int d = 0; d < 2; d++) begin
         bit [N-1:0] np;
         int nph, lim, g;
         if (!rst_n) begin
            m_pend[d] = '0; m_req[d] = 1'b0; m_xd[d] = '0; m_xch[d] = 0;
            m_last[d] = N - 1; m_ph[d] = 0; m_tmo[d] = 1'b0; m_entry[d] = e;
         end else begin
            np  = m_pend[d];
            nph = m_ph[d];
            lim = (d == 0) ? 8 : 0;
            case (m_ph[d])
               0: if (m_pend[d] != 0) begin
                  g = -1;
                  for (int k = 1; k <= N; k++)
                     if (g < 0 && m_pend[d][(m_last[d] + k) % N]) g = (m_last[d] + k) % N;
                  m_xd[d] = m_hold[d][g]; m_xch[d] = g; m_last[d] = g;
                  m_req[d] = (d == 0) ? 1'b1 : !m_req[d];
                  nph = (d == 0) ? 1 : 3;
               end
               1: if (ak[d] === 1'b1) begin m_req[d] = 1'b0; np[m_xch[d]] = 1'b0; nph = 2; end
               2: if (ak[d] === 1'b0) nph = 0;
               default: if (ak[d] === m_req[d]) begin np[m_xch[d]] = 1'b0; nph = 0; end
            endcase
            for (int i = 0; i < N; i++)
               if (sr[d][i] && !m_pend[d][i]) begin
                  np[i] = 1'b1;
                  m_hold[d][i] = dn[d][i*W +: W];
               end
            if (nph != m_ph[d]) begin m_entry[d] = e; m_tmo[d] = 1'b0; end
            else m_tmo[d] = (lim > 0 && nph != 0 && (e - m_entry[d]) == lim);
            m_pend[d] = np;
            m_ph[d]   = nph;
         end
      end
      m_edge = e;
      @(posedge clk);
      #1;
   endtask

   task automatic drain0();
      for (int t = 0; t < 30; t++) begin
         if (o_req[0] !== ak[0]) ak[0] = o_req[0];
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      for (int d = 0; d < 2; d++) begin
         nchk++; if (o_sidle[d] !== 4'hF) $display("FAIL reset_sidle[%0d] got %h exp f", d, o_sidle[d]); else npass++;
         nchk++; if (o_req[d] !== 1'b0) $display("FAIL reset_req[%0d] got %b exp 0", d, o_req[d]); else npass++;
         nchk++; if (o_xd[d] !== 32'h0) $display("FAIL reset_xdata[%0d] got %h exp 0", d, o_xd[d]); else npass++;
         nchk++; if (o_xch[d] !== 2'd0) $display("FAIL reset_xch[%0d] got %0d exp 0", d, o_xch[d]); else npass++;
         nchk++; if (o_tmo[d] !== 1'b0) $display("FAIL reset_timeout[%0d] got %b exp 0", d, o_tmo[d]); else npass++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic4();
      sr[0] = 4'b0100; dn[0][2*W +: W] = 32'hDEADBEEF;
      step();
      sr[0] = '0;
      nchk++; if (o_sidle[0] !== 4'b1011) $display("FAIL basic_capture_sidle got %b exp 1011", o_sidle[0]); else npass++;
      nchk++; if (o_req[0] !== 1'b0) $display("FAIL basic_req_early got %b exp 0", o_req[0]); else npass++;
      step();
      nchk++; if (o_req[0] !== 1'b1) $display("FAIL basic_req got %b exp 1", o_req[0]); else npass++;
      nchk++; if (o_xch[0] !== 2'd2) $display("FAIL basic_xch got %0d exp 2", o_xch[0]); else npass++;
      nchk++; if (o_xd[0] !== 32'hDEADBEEF) $display("FAIL basic_xdata got %h exp deadbeef", o_xd[0]); else npass++;
      step(); step(); step();
      nchk++; if (o_req[0] !== 1'b1) $display("FAIL basic_req_hold got %b exp 1", o_req[0]); else npass++;
      ak[0] = 1'b1;
      step();
      nchk++; if (o_req[0] !== 1'b0) $display("FAIL basic_req_drop got %b exp 0", o_req[0]); else npass++;
      nchk++; if (o_sidle[0] !== 4'hF) $display("FAIL basic_free_sidle got %b exp 1111", o_sidle[0]); else npass++;
      nchk++; if (o_xd[0] !== 32'hDEADBEEF) $display("FAIL basic_xdata_stable got %h exp deadbeef", o_xd[0]); else npass++;
      ak[0] = 1'b0;
      step(); step();
   endtask

   task automatic test_rr_order();
      int got [$];
      logic [W-1:0] gd [$];
      int exp_ch [6] = '{0, 1, 3, 0, 1, 3};
      int wc;
      bit prev;
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         sr[0] = 4'b1011;
         for (int i = 0; i < N; i++) dn[0][i*W +: W] = 32'hA0 + 32'(pass * 16 + i);
         step();
         sr[0] = '0; wc = 0; prev = 1'b0;
         for (int t = 0; t < 40; t++) begin
            if (o_req[0] && !ak[0]) begin wc++; if (wc == 3) ak[0] = 1'b1; end
            else if (!o_req[0] && ak[0]) begin ak[0] = 1'b0; wc = 0; end
            step();
            if (o_req[0] && !prev) begin got.push_back(int'(o_xch[0])); gd.push_back(o_xd[0]); end
            prev = o_req[0];
         end
      end
      nchk++; if (got.size() != 6) $display("FAIL rr_grant_count got %0d exp 6", got.size()); else npass++;
      for (int k = 0; k < 6 && k < got.size(); k++) begin
         nchk++; if (got[k] != exp_ch[k]) $display("FAIL rr_order[%0d] got %0d exp %0d", k, got[k], exp_ch[k]); else npass++;
         nchk++; if (gd[k] !== 32'hA0 + 32'((k / 3) * 16 + exp_ch[k]))
            $display("FAIL rr_data[%0d] got %h exp %h", k, gd[k], 32'hA0 + 32'((k / 3) * 16 + exp_ch[k])); else npass++;
      end
   endtask

   task automatic test_toggle();
      sr[1] = 4'b0010; dn[1][W +: W] = 32'h11;
      step();
      sr[1] = '0;
      nchk++; if (o_sidle[1] !== 4'b1101) $display("FAIL tog_capture got %b exp 1101", o_sidle[1]); else npass++;
      step();
      nchk++; if (o_req[1] !== 1'b1) $display("FAIL tog_req1 got %b exp 1", o_req[1]); else npass++;
      nchk++; if (o_xd[1] !== 32'h11) $display("FAIL tog_xdata1 got %h exp 11", o_xd[1]); else npass++;
      nchk++; if (o_xch[1] !== 2'd1) $display("FAIL tog_xch got %0d exp 1", o_xch[1]); else npass++;
      step();
      nchk++; if (o_sidle[1] !== 4'b1101) $display("FAIL tog_wait got %b exp 1101", o_sidle[1]); else npass++;
      ak[1] = 1'b1;
      step();
      nchk++; if (o_sidle[1] !== 4'hF) $display("FAIL tog_free1 got %b exp 1111", o_sidle[1]); else npass++;
      sr[1] = 4'b0010; dn[1][W +: W] = 32'h22;
      step();
      sr[1] = '0;
      step();
      nchk++; if (o_req[1] !== 1'b0) $display("FAIL tog_req2 got %b exp 0", o_req[1]); else npass++;
      nchk++; if (o_xd[1] !== 32'h22) $display("FAIL tog_xdata2 got %h exp 22", o_xd[1]); else npass++;
      step();
      nchk++; if (o_sidle[1] !== 4'b1101) $display("FAIL tog_wait2 got %b exp 1101", o_sidle[1]); else npass++;
      ak[1] = 1'b0;
      step();
      nchk++; if (o_sidle[1] !== 4'hF) $display("FAIL tog_free2 got %b exp 1111", o_sidle[1]); else npass++;
   endtask

   task automatic test_timeout();
      int pulses;
      pulses = 0;
      sr[0] = 4'b0001; dn[0][W-1:0] = 32'h77;
      step();
      sr[0] = '0;
      step();
      for (int n = 1; n <= 11; n++) begin
         step();
         if (o_tmo[0] === 1'b1) pulses++;
         nchk++; if (o_tmo[0] !== (n == 8)) $display("FAIL timeout_at_%0d got %b exp %b", n, o_tmo[0], (n == 8)); else npass++;
      end
      nchk++; if (pulses != 1) $display("FAIL timeout_pulses got %0d exp 1", pulses); else npass++;
      nchk++; if (o_req[0] !== 1'b1) $display("FAIL timeout_req_held got %b exp 1", o_req[0]); else npass++;
      ak[0] = 1'b1;
      step();
      nchk++; if (o_req[0] !== 1'b0) $display("FAIL timeout_late_ack got %b exp 0", o_req[0]); else npass++;
      nchk++; if (o_sidle[0] !== 4'hF) $display("FAIL timeout_free got %b exp 1111", o_sidle[0]); else npass++;
      ak[0] = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      sr[0] = 4'b0001; dn[0][W-1:0] = 32'h1;
      step(); sr[0] = '0; step();
      ak[0] = 1'b1; step();
      ak[0] = 1'b0; step();
      sr[0] = 4'b1001; dn[0][W-1:0] = 32'h2; dn[0][3*W +: W] = 32'h3;
      step(); sr[0] = '0; step();
      nchk++; if (o_xch[0] !== 2'd3) $display("FAIL rstmid_pre_xch got %0d exp 3", o_xch[0]); else npass++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      nchk++; if (o_req[0] !== 1'b0) $display("FAIL rstmid_req got %b exp 0", o_req[0]); else npass++;
      nchk++; if (o_xd[0] !== 32'h0) $display("FAIL rstmid_xdata got %h exp 0", o_xd[0]); else npass++;
      nchk++; if (o_sidle[0] !== 4'hF) $display("FAIL rstmid_sidle got %b exp 1111", o_sidle[0]); else npass++;
      sr[0] = 4'b1001; dn[0][W-1:0] = 32'h4; dn[0][3*W +: W] = 32'h5;
      step(); sr[0] = '0; step();
      nchk++; if (o_xch[0] !== 2'd0) $display("FAIL rstmid_next_xch got %0d exp 0", o_xch[0]); else npass++;
      nchk++; if (o_xd[0] !== 32'h4) $display("FAIL rstmid_next_xdata got %h exp 4", o_xd[0]); else npass++;
      drain0();
   endtask

   task automatic test_free_cycle();
      sr[0] = 4'b0001; dn[0][W-1:0] = 32'h5;
      step(); sr[0] = '0; step();
      ak[0] = 1'b1; sr[0] = 4'b0001; dn[0][W-1:0] = 32'h66;
      nchk++; if (o_sidle[0][0] !== 1'b0) $display("FAIL free_cycle_busy got %b exp 0", o_sidle[0][0]); else npass++;
      step();
      nchk++; if (o_sidle[0][0] !== 1'b1) $display("FAIL free_cycle_ignored got %b exp 1", o_sidle[0][0]); else npass++;
      step();
      nchk++; if (o_sidle[0][0] !== 1'b0) $display("FAIL free_cycle_recapture got %b exp 0", o_sidle[0][0]); else npass++;
      sr[0] = '0; ak[0] = 1'b0;
      step(); step();
      nchk++; if (o_req[0] !== 1'b1) $display("FAIL free_cycle_regrant got %b exp 1", o_req[0]); else npass++;
      nchk++; if (o_xd[0] !== 32'h66) $display("FAIL free_cycle_xdata got %h exp 66", o_xd[0]); else npass++;
      drain0();
   endtask

   task automatic test_random();
      for (int t = 0; t < 600; t++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         for (int d = 0; d < 2; d++) begin
            sr[d] = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int i = 0; i < N; i++) dn[d][i*W +: W] = $urandom();
            if (o_req[d] !== ak[d] && $urandom_range(0, 2) == 0) ak[d] = o_req[d];
         end
         step();
         for (int d = 0; d < 2; d++) begin
            nchk++; if (o_sidle[d] !== ~m_pend[d]) $display("FAIL rnd_sidle[%0d] t=%0d got %b exp %b", d, t, o_sidle[d], ~m_pend[d]); else npass++;
            nchk++; if (o_req[d] !== m_req[d]) $display("FAIL rnd_req[%0d] t=%0d got %b exp %b", d, t, o_req[d], m_req[d]); else npass++;
            nchk++; if (o_xd[d] !== m_xd[d]) $display("FAIL rnd_xdata[%0d] t=%0d got %h exp %h", d, t, o_xd[d], m_xd[d]); else npass++;
            nchk++; if (o_xch[d] !== 2'(m_xch[d])) $display("FAIL rnd_xch[%0d] t=%0d got %0d exp %0d", d, t, o_xch[d], m_xch[d]); else npass++;
            nchk++; if (o_tmo[d] !== m_tmo[d]) $display("FAIL rnd_timeout[%0d] t=%0d got %b exp %b", d, t, o_tmo[d], m_tmo[d]); else npass++;
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin sr[d] = '0; dn[d] = '0; ak[d] = 1'b0; end
      test_reset();
      test_basic4();
      test_rr_order();
      test_toggle();
      test_timeout();
      test_reset_mid();
      test_free_cycle();
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired after %0d checks", nchk);
      $fatal(1);
   end
endmodule
